// File: rtl/dsp_sequencer.sv
// Program-buffer instruction sequencer: loads words from a host, replays them to a DSP datapath.
// Optional abort port pair enabled by defining DSP_SEQ_ABORT_EN.
module dsp_sequencer #(
  parameter int          PROG_DEPTH = 8,
  parameter int          ISSUE_GAP  = 2,
  parameter logic [2:0]  NOP_OP     = 3'b111
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [10:0]                   ld_instr,
  input  logic                          start,
  input  logic                          clear,
  input  logic [3:0]                    loop_cnt,
  output logic [2:0]                    opcode,
  output logic [3:0]                    mem_addr,
  output logic [3:0]                    imm_val,
  output logic                          issue,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          done
`ifdef DSP_SEQ_ABORT_EN
  ,
  input  logic                          abort,
  output logic                          aborted
`endif
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [3:0]      passes_q, passes_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            aborted_q, aborted_d;
  logic [10:0]     prog_q [PROG_DEPTH];

  logic            ld_fire;
  logic            last_entry;
  logic            advance;
  logic            abort_req;

  always_comb begin
    ld_ready   = (state_q == S_IDLE) && (count_q < CW'(PROG_DEPTH));
    ld_fire    = ld_ready && ld_valid && !clear;
    last_entry = ({1'b0, pc_q} == (count_q - CW'(1)));
`ifdef DSP_SEQ_ABORT_EN
    abort_req  = abort && ((state_q == S_RUN) || (state_q == S_WAIT));
`else
    abort_req  = 1'b0;
`endif

    state_d   = state_q;
    count_d   = count_q;
    wp_d      = wp_q;
    pc_d      = pc_q;
    passes_d  = passes_q;
    gap_d     = gap_q;
    aborted_d = 1'b0;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
          wp_d    = '0;
        end else begin
          if (ld_fire) begin
            wp_d    = wp_q + AW'(1);
            count_d = count_q + CW'(1);
          end
          // A word accepted alongside start is part of this run.
          if (start && ((count_q != '0) || ld_fire)) begin
            state_d  = S_RUN;
            pc_d     = '0;
            passes_d = loop_cnt;
          end
        end
      end
      S_RUN: begin
        if (ISSUE_GAP > 1) begin
          state_d = S_WAIT;
          gap_d   = GW'(ISSUE_GAP - 2);
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT: begin
        if (gap_q == '0) advance = 1'b1;
        else             gap_d   = gap_q - GW'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!last_entry) begin
        pc_d    = pc_q + AW'(1);
        state_d = S_RUN;
      end else if (passes_q != '0) begin
        pc_d     = '0;
        passes_d = passes_q - 4'd1;
        state_d  = S_RUN;
      end else begin
        state_d = S_DONE;
      end
    end

    if (abort_req) begin
      state_d   = S_IDLE;
      pc_d      = '0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      wp_q      <= '0;
      pc_q      <= '0;
      passes_q  <= '0;
      gap_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wp_q      <= wp_d;
      pc_q      <= pc_d;
      passes_q  <= passes_d;
      gap_q     <= gap_d;
      aborted_q <= aborted_d;
    end
  end

  // Buffer contents survive reset; only count/wp define what is valid.
  always_ff @(posedge clk) begin
    if (ld_fire) prog_q[wp_q] <= ld_instr;
  end

  always_comb begin
    issue    = (state_q == S_RUN);
    busy     = (state_q == S_RUN) || (state_q == S_WAIT);
    done     = (state_q == S_DONE);
    pc       = pc_q;
    opcode   = NOP_OP;
    mem_addr = '0;
    imm_val  = '0;
    if (issue) {opcode, mem_addr, imm_val} = prog_q[pc_q];
  end

`ifdef DSP_SEQ_ABORT_EN
  assign aborted = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed self-checking bench for dsp_sequencer (default PROG_DEPTH=8, ISSUE_GAP=2).
module tb_dsp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [10:0] ld_instr;
  logic        start;
  logic        clear;
  logic [3:0]  loop_cnt;
  logic [2:0]  opcode;
  logic [3:0]  mem_addr;
  logic [3:0]  imm_val;
  logic        issue;
  logic [2:0]  pc;
  logic        busy;
  logic        done;
`ifdef DSP_SEQ_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_sequencer #(.PROG_DEPTH(8), .ISSUE_GAP(2), .NOP_OP(3'b111)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_instr(ld_instr),
    .start(start), .clear(clear), .loop_cnt(loop_cnt), .opcode(opcode),
    .mem_addr(mem_addr), .imm_val(imm_val), .issue(issue), .pc(pc), .busy(busy), .done(done)
`ifdef DSP_SEQ_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkw(input int i);
    logic [2:0] op;
    logic [3:0] ad;
    logic [3:0] im;
    op = 3'(i % 7);
    ad = 4'(i * 3 + 1);
    im = 4'(15 - i);
    return {op, ad, im};
  endfunction

  task automatic load_word(input logic [10:0] w);
    ld_valid = 1'b1;
    ld_instr = w;
    chk("ld_ready_load", ld_ready, 1);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] lc);
    start    = 1'b1;
    loop_cnt = lc;
    step();
    start    = 1'b0;
  endtask

  // Bounded observation window: counts issues/done pulses and records first/last issued word.
  task automatic run_watch(input int cycles, output int n_iss, output int n_done,
                           output logic [10:0] first_w, output logic [10:0] last_w);
    n_iss = 0; n_done = 0; first_w = '0; last_w = '0;
    for (int i = 0; i < cycles; i++) begin
      if (issue) begin
        if (n_iss == 0) first_w = {opcode, mem_addr, imm_val};
        last_w = {opcode, mem_addr, imm_val};
        n_iss++;
      end
      if (done) n_done++;
      step();
    end
  endtask

  initial begin
    int          ni, nd;
    logic [10:0] fw, lw;
    logic [10:0] w3 [3];
    bit          exp_iss;
    int          ent;

    rst = 1'b1; ld_valid = 1'b0; ld_instr = '0; start = 1'b0; clear = 1'b0; loop_cnt = '0;
`ifdef DSP_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    step(); step();
    chk("rst_issue", issue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_opcode", opcode, 3'b111);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_imm_val", imm_val, 0);
    chk("rst_pc", pc, 0);
    rst = 1'b0;
    chk("ld_ready_after_rst", ld_ready, 1);

    // Three-word program, two passes, exact issue timing.
    for (int i = 0; i < 3; i++) begin
      w3[i] = mkw(i);
      load_word(w3[i]);
    end
    start_run(4'd1);
    for (int k = 1; k <= 13; k++) begin
      exp_iss = (k % 2 == 1) && (k <= 11);
      ent     = ((k - 1) / 2) % 3;
      chk($sformatf("t1_issue_k%0d", k), issue, exp_iss);
      chk($sformatf("t1_done_k%0d", k), done, (k == 13));
      chk($sformatf("t1_busy_k%0d", k), busy, (k <= 12));
      if (exp_iss) begin
        chk($sformatf("t1_word_k%0d", k), {opcode, mem_addr, imm_val}, w3[ent]);
        chk($sformatf("t1_pc_k%0d", k), pc, ent);
      end
      if (k == 2) chk("t1_nop_opcode", opcode, 3'b111);
      step();
    end
    chk("t1_idle_ready", ld_ready, 1);
    chk("t1_idle_busy", busy, 0);

    // Replay of retained program, single pass.
    start_run(4'd0);
    run_watch(12, ni, nd, fw, lw);
    chk("replay_issues", ni, 3);
    chk("replay_done", nd, 1);
    chk("replay_first", fw, w3[0]);
    chk("replay_last", lw, w3[2]);

    // Empty buffer: start ignored.
    do_clear();
    start_run(4'd0);
    chk("empty_busy", busy, 0);
    run_watch(6, ni, nd, fw, lw);
    chk("empty_issues", ni, 0);
    chk("empty_done", nd, 0);

    // Fill to capacity, ninth word refused.
    for (int i = 0; i < 8; i++) load_word(mkw(i + 3));
    chk("full_ready", ld_ready, 0);
    ld_valid = 1'b1; ld_instr = 11'h7ff;
    step();
    ld_valid = 1'b0;
    chk("full_ready_after9", ld_ready, 0);
    start_run(4'd0);
    run_watch(20, ni, nd, fw, lw);
    chk("full_issues", ni, 8);
    chk("full_done", nd, 1);
    chk("full_first", fw, mkw(3));
    chk("full_last", lw, mkw(10));

    // Load and start in the same cycle with two words already buffered.
    do_clear();
    load_word(mkw(0));
    load_word(mkw(1));
    ld_valid = 1'b1; ld_instr = mkw(2);
    start_run(4'd0);
    ld_valid = 1'b0;
    run_watch(12, ni, nd, fw, lw);
    chk("ldstart_issues", ni, 3);
    chk("ldstart_last", lw, mkw(2));
    chk("ldstart_done", nd, 1);

    // Clear wins over a same-cycle start, and the buffer stays empty afterwards.
    clear = 1'b1;
    start_run(4'd0);
    clear = 1'b0;
    run_watch(4, ni, nd, fw, lw);
    chk("clrstart_issues", ni, 0);
    start_run(4'd0);
    run_watch(4, ni, nd, fw, lw);
    chk("clrstart_empty_issues", ni, 0);
    chk("clrstart_empty_done", nd, 0);

    // Reset during WAIT of entry 1.
    for (int i = 0; i < 3; i++) load_word(w3[i]);
    start_run(4'd0);
    step(); step(); step();
    chk("rstmid_busy_pre", busy, 1);
    chk("rstmid_pc_pre", pc, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_issue", issue, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_opcode", opcode, 3'b111);
    chk("rstmid_pc", pc, 0);
    step();
    rst = 1'b0;
    chk("rstmid_ready", ld_ready, 1);
    run_watch(8, ni, nd, fw, lw);
    chk("rstmid_no_done", nd, 0);
    chk("rstmid_no_issue", ni, 0);

`ifdef DSP_SEQ_ABORT_EN
    for (int i = 0; i < 3; i++) load_word(w3[i]);
    start_run(4'd0);
    step(); step();
    chk("abort_at_issue2", issue, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pc", pc, 0);
    step();
    chk("abort_pulse_end", aborted, 0);
    start_run(4'd0);
    chk("abort_replay_word", {opcode, mem_addr, imm_val}, w3[0]);
    run_watch(12, ni, nd, fw, lw);
    chk("abort_replay_issues", ni, 3);
    chk("abort_replay_done", nd, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_sequencer.md
DSP_SEQUENCER -- requirements
Module: dsp_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 8: program buffer entries, power of two, 2..16.
REQ-002 SHALL have parameter ISSUE_GAP, default 2: cycles per issued instruction, at least 1.
REQ-003 SHALL have parameter NOP_OP, default 3'b111: opcode driven when not issuing.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port ld_valid  input  1  host offers a program word.
REQ-007 SHALL have port ld_ready  output  1  sequencer accepts a word this cycle.
REQ-008 SHALL have port ld_instr  input  11  program word: [10:8] opcode, [7:4] mem_addr, [3:0] imm_val.
REQ-009 SHALL have port start  input  1  begin executing the buffered program.
REQ-010 SHALL have port clear  input  1  empty the program buffer.
REQ-011 SHALL have port loop_cnt  input  4  extra passes over the program, sampled at start.
REQ-012 SHALL have ports opcode/mem_addr/imm_val  output  3/4/4  instruction presented to the DSP datapath.
REQ-013 SHALL have port issue  output  1  outputs carry a real instruction this cycle.
REQ-014 SHALL have port pc  output  clog2(PROG_DEPTH)  index of the current or last issued entry.
REQ-015 SHALL have ports busy and done  output  1 each  executing; one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN, WAIT and DONE; RUN is exactly one cycle with issue=1.
REQ-017 SHALL drive ld_ready=1 only in IDLE with count<PROG_DEPTH; a handshake writes the buffer at wp, then increments wp and count.
REQ-018 SHALL, in IDLE, treat start with count>0 as IDLE->RUN on the next cycle (pc=0, passes=loop_cnt); start with count=0 is ignored.
REQ-019 SHALL include a word accepted in the same cycle as start in the run, with count including it.
REQ-020 SHALL, in RUN, drive buffer[pc] fields on opcode/mem_addr/imm_val.
REQ-021 SHALL drive opcode=NOP_OP, mem_addr=0 and imm_val=0 in all other cycles.
REQ-022 SHALL go RUN->WAIT for ISSUE_GAP-1 cycles; with ISSUE_GAP=1 it goes RUN->RUN directly.
REQ-023 SHALL, after the gap of entry pc<count-1, increment pc and re-enter RUN.
REQ-024 SHALL, after the gap of entry pc=count-1, set pc=0 and passes-=1 and re-enter RUN if passes>0, else enter DONE.
REQ-025 SHALL execute the program loop_cnt+1 times in total.
REQ-026 SHALL hold done=1 and busy=0 for the single DONE cycle, then return to IDLE.
REQ-027 SHALL retain the buffer contents and count after a run, so a new start replays the program.
REQ-028 SHALL hold busy=1 in RUN and WAIT, and ignore start, clear and ld_valid while busy.
REQ-029 SHALL, on clear in IDLE, zero count and wp next cycle; clear takes priority over a same-cycle load and start.

Reset
REQ-030 SHALL, on rst, force immediately: state=IDLE, count=0, wp=0, pc=0, passes=0, issue=0, busy=0, done=0, opcode=NOP_OP, mem_addr=0, imm_val=0.
REQ-031 SHALL drive ld_ready=1 in the first cycle after rst deasserts.
REQ-032 SHALL abandon a run on rst mid-run with no done pulse; buffer contents need not be cleared.

Configuration
REQ-033 SHALL, with macro DSP_SEQ_ABORT_EN defined, add input abort and output aborted.
REQ-034 SHALL, with DSP_SEQ_ABORT_EN defined, treat abort in RUN/WAIT as: IDLE next cycle, pc=0, aborted pulsed one cycle, no done, buffer kept; abort in IDLE/DONE is ignored.
REQ-035 SHALL, without DSP_SEQ_ABORT_EN, omit both ports so a run always completes.

Verification
REQ-036 SHALL cover: load 3 words, ISSUE_GAP=2, loop_cnt=1, start at cycle T -> issue at T+1,3,5,7,9,11 with entries 0,1,2,0,1,2; done at T+13 only.
REQ-037 SHALL cover: load 8 words, PROG_DEPTH=8 -> ld_ready=0 after the 8th word; a 9th ld_valid is not accepted and count stays 8.
REQ-038 SHALL cover: start with empty buffer -> stays IDLE, busy=0, no issue, no done.
REQ-039 SHALL cover: ld_valid and start together with count=2 -> run issues 3 entries; clear with start together -> count=0, no run.
REQ-040 SHALL cover: rst asserted during WAIT of entry 1 -> outputs at reset values immediately, opcode=3'b111, no done.
REQ-041 SHALL cover (DSP_SEQ_ABORT_EN): abort at second issue -> aborted pulse next cycle, IDLE; a restart replays from entry 0.
